// File: rtl/accum_xcel_sched_if.sv
// ============================================================================
// Module   : accum_xcel_sched_if
// Purpose  : Command/response val-rdy bundle between the processor side and
//            the accumulate-job scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accum_xcel_sched_if;
    logic        cmd_val;
    logic        cmd_rdy;
    logic [13:0] cmd_size;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_result;
    logic [13:0] resp_size;

    // Processor side issues commands and consumes responses.
    modport master (
        output cmd_val,
        output cmd_size,
        output resp_rdy,
        input  cmd_rdy,
        input  resp_val,
        input  resp_result,
        input  resp_size
    );

    // Scheduler side accepts commands and produces responses.
    modport slave (
        input  cmd_val,
        input  cmd_size,
        input  resp_rdy,
        output cmd_rdy,
        output resp_val,
        output resp_result,
        output resp_size
    );
endinterface

`default_nettype wire

// File: rtl/accum_xcel_sched.sv
// ============================================================================
// Module   : accum_xcel_sched
// Purpose  : Queues accumulate jobs, runs the accelerator one job at a time
//            and returns each 32-bit result. Optional per-job cycle count
//            enabled by defining ACCUM_XCEL_SCHED_CYCLES_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_xcel_sched #(
    parameter int QDEPTH = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    accum_xcel_sched_if.slave    bus,
    output logic                 xcel_go,
    output logic [13:0]          xcel_size,
    input  wire                  xcel_result_val,
    input  wire  [31:0]          xcel_result,
    output logic                 busy
`ifdef ACCUM_XCEL_SCHED_CYCLES_EN
    ,
    output logic [15:0]          resp_cycles
`endif
);

    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(QDEPTH);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_GO   = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;
    localparam logic [1:0] c_S_RESP = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [13:0]        r_mem [QDEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [31:0]        r_resp_result;
    logic [13:0]        r_resp_size;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_zero_job;
    logic [13:0]        w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_head  = r_mem[r_rd_ptr];
    // Ready depends only on the registered count, so a full queue refuses
    // a command even on the edge where the head is being popped.
    assign w_push  = bus.cmd_val && !w_full;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_zero_job  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!w_empty) begin
                    if (w_head == 14'd0) begin
                        w_state_nxt = c_S_RESP;
                        w_pop       = 1'b1;
                        w_zero_job  = 1'b1;
                    end else begin
                        w_state_nxt = c_S_GO;
                    end
                end
            end
            c_S_GO: begin
                w_state_nxt = c_S_WAIT;
            end
            c_S_WAIT: begin
                if (xcel_result_val) begin
                    w_state_nxt = c_S_RESP;
                    w_pop       = 1'b1;
                    w_capture   = 1'b1;
                end
            end
            c_S_RESP: begin
                if (bus.resp_rdy) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.cmd_size;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_result <= '0;
            r_resp_size   <= '0;
        end else if (w_capture) begin
            r_resp_result <= xcel_result;
            r_resp_size   <= w_head;
        end else if (w_zero_job) begin
            r_resp_result <= '0;
            r_resp_size   <= '0;
        end
    end

`ifdef ACCUM_XCEL_SCHED_CYCLES_EN
    logic [15:0] r_cyc_cnt;
    logic [15:0] r_resp_cycles;
    logic [15:0] w_cyc_inc;

    // The captured value includes the capture cycle itself.
    assign w_cyc_inc = (r_cyc_cnt == 16'hFFFF) ? 16'hFFFF : r_cyc_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt     <= '0;
            r_resp_cycles <= '0;
        end else begin
            if (r_state == c_S_IDLE && w_state_nxt == c_S_GO) begin
                r_cyc_cnt <= '0;
            end else if (r_state == c_S_GO || r_state == c_S_WAIT) begin
                r_cyc_cnt <= w_cyc_inc;
            end
            if (w_capture) begin
                r_resp_cycles <= w_cyc_inc;
            end else if (w_zero_job) begin
                r_resp_cycles <= '0;
            end
        end
    end

    assign resp_cycles = r_resp_cycles;
`endif

    assign bus.cmd_rdy     = !w_full;
    assign bus.resp_val    = (r_state == c_S_RESP);
    assign bus.resp_result = r_resp_result;
    assign bus.resp_size   = r_resp_size;

    assign xcel_go   = (r_state == c_S_GO);
    assign xcel_size = (r_state == c_S_GO || r_state == c_S_WAIT) ? w_head : 14'd0;
    assign busy      = (r_state != c_S_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_accum_xcel_sched.sv
// ============================================================================
// Module   : tb_accum_xcel_sched
// Purpose  : Scoreboard bench for accum_xcel_sched with a behavioural
//            accumulate accelerator (result = 1+2+..+size).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_xcel_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accum_xcel_sched_if bus ();

    logic        xcel_go;
    logic [13:0] xcel_size;
    wire         xcel_result_val;
    wire  [31:0] xcel_result;
    logic        busy;
`ifdef ACCUM_XCEL_SCHED_CYCLES_EN
    logic [15:0] resp_cycles;
`endif

    logic        mdl_val  = 1'b0;
    logic [31:0] mdl_res  = '0;
    logic        spur_val = 1'b0;
    logic [31:0] spur_res = '0;
    assign xcel_result_val = mdl_val | spur_val;
    assign xcel_result     = spur_val ? spur_res : mdl_res;

    accum_xcel_sched #(.QDEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .xcel_go         (xcel_go),
        .xcel_size       (xcel_size),
        .xcel_result_val (xcel_result_val),
        .xcel_result     (xcel_result),
        .busy            (busy)
`ifdef ACCUM_XCEL_SCHED_CYCLES_EN
        ,
        .resp_cycles     (resp_cycles)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic [13:0] sz;
        logic [15:0] cyc;
        bit          chk_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] go_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_resp   = 0;
    int n_go     = 0;
    int lat      = 2;
    bit accel_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: go pulses and response handshakes against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic [13:0] g;
        if (rst) begin
            if (xcel_go) begin
                n_go++;
                if (go_q.size() == 0) begin
                    fail_evt("unexpected_go");
                end else begin
                    g = go_q.pop_front();
                    check("go_size", {18'd0, xcel_size}, {18'd0, g});
                end
            end
            if (bus.resp_val && bus.resp_rdy) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    fail_evt("unexpected_resp");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_result", bus.resp_result, e.res);
                    check("resp_size", {18'd0, bus.resp_size}, {18'd0, e.sz});
`ifdef ACCUM_XCEL_SCHED_CYCLES_EN
                    if (e.chk_cyc) check("resp_cycles", {16'd0, resp_cycles}, {16'd0, e.cyc});
`endif
                end
            end
        end
    end

    // Accelerator model: result appears `lat` cycles after go, or later while held.
    initial begin
        logic [13:0] m_sz;
        bit          m_ok;
        forever begin
            @(negedge clk);
            if (rst && xcel_go) begin
                m_sz = xcel_size;
                m_ok = 1'b1;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (!rst) m_ok = 1'b0;
                end
                while (m_ok && accel_hold) begin
                    @(negedge clk);
                    if (!rst) m_ok = 1'b0;
                end
                if (m_ok && rst) begin
                    mdl_res = (32'(m_sz) * (32'(m_sz) + 32'd1)) / 32'd2;
                    mdl_val = 1'b1;
                    @(negedge clk);
                    mdl_val = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [13:0] sz, input logic [31:0] res,
                        input logic [15:0] cyc, input bit chk);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        bus.cmd_val  = 1'b1;
        bus.cmd_size = sz;
        while (!bus.cmd_rdy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_rdy) begin
            fail_evt("cmd_accept_timeout");
            bus.cmd_val = 1'b0;
            return;
        end
        e.res = res; e.sz = sz; e.cyc = cyc; e.chk_cyc = chk;
        exp_q.push_back(e);
        if (sz != 14'd0) go_q.push_back(sz);
        @(posedge clk);
        #1 bus.cmd_val = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int c = 0;
        while ((exp_q.size() != 0 || go_q.size() != 0) && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0 || go_q.size() != 0) fail_evt("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        int   go_before;
        int   resp_before;
        bit   ok;
        exp_t e;

        bus.cmd_val  = 1'b0;
        bus.cmd_size = '0;
        bus.resp_rdy = 1'b1;

        // Reset values
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        check("rst_resp_val", {31'd0, bus.resp_val}, 32'd0);
        check("rst_resp_result", bus.resp_result, 32'd0);
        check("rst_resp_size", {18'd0, bus.resp_size}, 32'd0);
        check("rst_xcel_go", {31'd0, xcel_go}, 32'd0);
        check("rst_xcel_size", {18'd0, xcel_size}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef ACCUM_XCEL_SCHED_CYCLES_EN
        check("rst_resp_cycles", {16'd0, resp_cycles}, 32'd0);
`endif
        rst = 1'b1;

        // Single job: size 8, accelerator answers 10 cycles after go
        lat = 10;
        send(14'd8, 32'd36, 16'd11, 1'b1);
        @(negedge clk);
        check("go_cycle_e0", {31'd0, xcel_go}, 32'd0);
        @(negedge clk);
        check("go_cycle_e1", {31'd0, xcel_go}, 32'd1);
        check("go_xcel_size", {18'd0, xcel_size}, 32'd8);
        wait_drain(100);
        lat = 2;

        // Size-0 job: response in the second cycle, no go
        send(14'd0, 32'd0, 16'd0, 1'b1);
        @(negedge clk);
        check("zero_resp_e0", {31'd0, bus.resp_val}, 32'd0);
        @(negedge clk);
        check("zero_resp_e1", {31'd0, bus.resp_val}, 32'd1);
        wait_drain(50);

        // Queue fill with first job stalled
        accel_hold = 1'b1;
        send(14'd1, 32'd1, 16'd0, 1'b0);
        send(14'd2, 32'd3, 16'd3, 1'b1);
        send(14'd3, 32'd6, 16'd3, 1'b1);
        send(14'd4, 32'd10, 16'd3, 1'b1);
        @(negedge clk);
        check("qfull_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        check("qfull_busy", {31'd0, busy}, 32'd1);
        fork
            send(14'd5, 32'd15, 16'd3, 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1 accel_hold = 1'b0;
            end
        join
        wait_drain(200);

        // Backpressure with a spurious result strobe during RESP
        bus.resp_rdy = 1'b0;
        send(14'd2, 32'd3, 16'd3, 1'b1);
        send(14'd3, 32'd6, 16'd3, 1'b1);
        c = 0;
        while (!bus.resp_val && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!bus.resp_val) fail_evt("bp_resp_timeout");
        go_before = n_go;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_result !== 32'd3 || bus.resp_size !== 14'd2 || bus.resp_val !== 1'b1) ok = 1'b0;
            if (i == 5) begin
                spur_res = 32'hDEADBEEF;
                spur_val = 1'b1;
            end
            if (i == 6) spur_val = 1'b0;
        end
        check("bp_stable", {31'd0, ok}, 32'd1);
        check("bp_no_go", 32'(n_go - go_before), 32'd0);
        bus.resp_rdy = 1'b1;
        wait_drain(100);

        // Simultaneous push and pop at WAIT capture with count 2
        accel_hold = 1'b1;
        send(14'd3, 32'd6, 16'd0, 1'b0);
        repeat (4) @(posedge clk);
        send(14'd4, 32'd10, 16'd3, 1'b1);
        @(posedge clk);
        #1 accel_hold = 1'b0;
        @(negedge clk);
        check("simul_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        bus.cmd_val  = 1'b1;
        bus.cmd_size = 14'd5;
        e.res = 32'd15; e.sz = 14'd5; e.cyc = 16'd3; e.chk_cyc = 1'b1;
        exp_q.push_back(e);
        go_q.push_back(14'd5);
        @(posedge clk);
        #1 bus.cmd_val = 1'b0;
        check("simul_count", 32'(dut.r_count), 32'd2);
        check("simul_resp_val", {31'd0, bus.resp_val}, 32'd1);
        wait_drain(200);

        // Asynchronous reset while WAITing with 3 jobs queued
        accel_hold = 1'b1;
        send(14'd7, 32'd28, 16'd0, 1'b0);
        send(14'd8, 32'd36, 16'd0, 1'b0);
        send(14'd9, 32'd45, 16'd0, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        check("arst_resp_val", {31'd0, bus.resp_val}, 32'd0);
        check("arst_xcel_size", {18'd0, xcel_size}, 32'd0);
        exp_q.delete();
        go_q.delete();
        resp_before = n_resp;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        accel_hold = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("arst_no_resp", 32'(n_resp - resp_before), 32'd0);
        check("arst_idle_busy", {31'd0, busy}, 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/accum_xcel_sched.md
# accum_xcel_sched

Job scheduler that sits between the processor's accelerator command interface and the accumulate accelerator. It buffers accumulate jobs (element counts) in a small FIFO, sequences the accelerator one job at a time with a single-cycle `go` pulse, captures each 32-bit result, and returns it over a val/rdy response port. It owns the accelerator's `go`/`size` inputs exclusively.

## Interface
- `QDEPTH`, 4: command FIFO depth; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_val`  in  1  command valid.
- `cmd_rdy`  out  1  command ready; equals `!full`.
- `cmd_size`  in  14  number of words to accumulate.
- `resp_val`  out  1  response valid.
- `resp_rdy`  in  1  response ready.
- `resp_result`  out  32  accumulated sum.
- `resp_size`  out  14  echo of the job's size.
- `xcel_go`  out  1  start pulse to the accelerator.
- `xcel_size`  out  14  job size to the accelerator.
- `xcel_result_val`  in  1  accelerator result valid.
- `xcel_result`  in  32  accelerator result.
- `busy`  out  1  high when state is not IDLE or the FIFO is non-empty.
- `resp_cycles`  out  16  per-job cycle count; present only with `ACCUM_XCEL_SCHED_CYCLES_EN`.

## Operation
- FIFO:
  - A push occurs on an edge where `cmd_val && cmd_rdy`.
  - `cmd_rdy` comes from the registered count only. When the FIFO is full it stays 0, even in a cycle where a pop occurs.
  - Pointers wrap modulo `QDEPTH`. The count is `$clog2(QDEPTH)+1` bits.
- FSM states: IDLE, GO, WAIT, RESP.
  - IDLE: FIFO non-empty and head size ≠ 0 → GO. FIFO non-empty and head size = 0 → RESP, with result 0 and the head popped. No `go` is issued for a size-0 job.
  - GO: `xcel_go`=1 for exactly this one cycle. Always → WAIT.
  - WAIT: on `xcel_result_val`, capture `xcel_result` and head size into the response registers, pop the head, → RESP.
  - RESP: `resp_val`=1, with `resp_result`/`resp_size` held stable. On `resp_rdy` → IDLE.
- `xcel_size` is driven from the FIFO head during GO and WAIT, and is 0 otherwise.
- `xcel_result_val` is ignored in every state except WAIT.
- Only one job is in flight at a time. Later commands keep queuing while a job runs.
- No arithmetic is performed on results; they pass through unmodified at 32 bits.

## Timing
- Reset values (on `rst`=0, asynchronous):
  - State is IDLE and the FIFO is empty.
  - `cmd_rdy`=1.
  - `resp_val`=0, `resp_result`=0, `resp_size`=0.
  - `xcel_go`=0, `xcel_size`=0, `busy`=0, `resp_cycles`=0.
- Reset mid-job discards the queue and any captured result. The accelerator is reset on the same `rst`.
- Latency, with the command accepted at edge E0 into an empty, idle block:
  - IDLE sees non-empty in cycle E0→E1.
  - GO occupies cycle E1→E2, so `xcel_go` is high there.
  - WAIT starts at E2.
- Result path: `xcel_result_val` sampled at edge Ek moves the FSM to RESP, and `resp_val` is high in the following cycle. Best-case job-to-response overhead is 3 cycles beyond the accelerator's own latency.
- A size-0 job accepted at E0 gives `resp_val` high in cycle E1→E2.
- Back-to-back jobs: RESP → IDLE → GO means a minimum of 2 cycles between the handshake edge and the next `xcel_go`.
- Simultaneous push and pop (WAIT capture plus `cmd_val` while not full): both take effect and the count is unchanged.
- `resp_val` stays high indefinitely while `resp_rdy`=0. The FIFO keeps accepting commands until full.

## Configuration
- `ACCUM_XCEL_SCHED_CYCLES_EN` defined:
  - A 16-bit counter clears on entry to GO and increments every cycle in GO and WAIT.
  - It saturates at 0xFFFF.
  - It is latched into `resp_cycles` at WAIT capture.
  - Size-0 jobs report 0.
- Not defined: the counter and the `resp_cycles` port are absent. All other behaviour is identical.

## Test plan
- Single job: size=8 and the accelerator model returns 36 after 10 cycles → exactly one `xcel_go` pulse with `xcel_size`=8, then `resp_val` with result 36 and size 8. With the macro, `resp_cycles`=11.
- Queue fill: 5 commands (sizes 1–5) with `QDEPTH`=4 while the first job is stalled → `cmd_rdy`=0 after 4 accepted; the 5th is accepted after the first pop. Responses come out in order 1–5.
- Size 0: `cmd_size`=0 → `resp_val` 2 cycles later with result 0, size 0, and `xcel_go` never asserted.
- Backpressure: `resp_rdy`=0 for 20 cycles → `resp_result` stable and no new `xcel_go` until the handshake. A spurious `xcel_result_val` in RESP is ignored.
- Async reset asserted in WAIT with 3 jobs queued → `busy`=0 and `cmd_rdy`=1 immediately. No response is emitted after release.
- Simultaneous push and pop at WAIT capture with count=2 → count stays 2 and the next job issues correctly.
